// File: rtl/render_tunnel.sv
// Animated tunnel renderer: background plus concentric squares, redrawn on each start.
// Filled and outline raster drawers share the shape registers; the latched mode selects one.
module render_tunnel #(
    parameter int unsigned CORDW      = 16,
    parameter int unsigned CIDXW      = 4,
    parameter int unsigned SCALE      = 1,
    parameter int unsigned WIDTH      = 320,
    parameter int unsigned HEIGHT     = 180,
    parameter int unsigned SHAPE_CNT  = 8,
    parameter int unsigned ANIM_CNT   = 5,
    parameter int unsigned ANIM_SPEED = 3,
    parameter int unsigned RING       = 10,
    parameter int unsigned GROW       = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    oe,
    input  logic                    start,
    input  logic                    dir,
    input  logic                    pause,
    input  logic                    outline,
    output logic signed [CORDW-1:0] x,
    output logic signed [CORDW-1:0] y,
    output logic [CIDXW-1:0]        cidx,
    output logic                    drawing,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned SIDW = $clog2(SHAPE_CNT);
    localparam int unsigned AW   = $clog2(ANIM_CNT);
    localparam int unsigned SW   = (ANIM_SPEED > 1) ? $clog2(ANIM_SPEED) : 1;

    localparam logic signed [CORDW-1:0] CxS    = CORDW'(WIDTH / 2);
    localparam logic signed [CORDW-1:0] CyS    = CORDW'(HEIGHT / 2);
    localparam logic signed [CORDW-1:0] WMaxS  = CORDW'(WIDTH - 1);
    localparam logic signed [CORDW-1:0] HMaxS  = CORDW'(HEIGHT - 1);
    localparam logic signed [CORDW-1:0] RingS  = CORDW'(RING);
    localparam logic signed [CORDW-1:0] GrowS  = CORDW'(GROW);
    localparam logic signed [CORDW-1:0] ScaleS = CORDW'(SCALE);
    localparam logic signed [CORDW-1:0] CntS   = CORDW'(SHAPE_CNT);

    typedef enum logic [1:0] {StIdle, StInit, StDraw, StDone} state_e;

    state_e state_q, state_d;

    logic [SIDW-1:0]  shape_id_q;
    logic [AW-1:0]    cnt_anim_q;
    logic [SW-1:0]    cnt_speed_q;
    logic [CIDXW-1:0] colr_offs_q;
    logic [CIDXW-1:0] cidx_q;
    logic             outline_q;
    logic [1:0]       draw_start_q;

    logic signed [CORDW-1:0] sx0_q, sy0_q, sx1_q, sy1_q;
    logic signed [CORDW-1:0] gx0, gy0, gx1, gy1, k, h, a_s;

    logic signed [CORDW-1:0] drw_x [2];
    logic signed [CORDW-1:0] drw_y [2];
    logic                    drw_act [2];
    logic                    drw_done [2];

    logic accept, last_shape, sel_done;

    assign accept     = (state_q == StIdle) && start;
    assign last_shape = (shape_id_q == SIDW'(SHAPE_CNT - 1));
    assign sel_done   = outline_q ? drw_done[1] : drw_done[0];

    // Animation counters advance only on an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_anim_q  <= '0;
            cnt_speed_q <= '0;
            colr_offs_q <= '0;
            outline_q   <= 1'b0;
        end else if (accept) begin
            outline_q <= outline;
            if (!pause) begin
                if (cnt_speed_q == SW'(ANIM_SPEED - 1)) begin
                    cnt_speed_q <= '0;
                    if (!dir) begin
                        if (cnt_anim_q == AW'(ANIM_CNT - 1)) begin
                            cnt_anim_q  <= '0;
                            colr_offs_q <= colr_offs_q + 1'b1;
                        end else begin
                            cnt_anim_q <= cnt_anim_q + 1'b1;
                        end
                    end else begin
                        if (cnt_anim_q == '0) begin
                            cnt_anim_q  <= AW'(ANIM_CNT - 1);
                            colr_offs_q <= colr_offs_q - 1'b1;
                        end else begin
                            cnt_anim_q <= cnt_anim_q - 1'b1;
                        end
                    end
                end else begin
                    cnt_speed_q <= cnt_speed_q + 1'b1;
                end
            end
        end
    end

    // Shape corners before scaling; shape 0 is the full-screen background.
    always_comb begin
        a_s = $signed(CORDW'(cnt_anim_q));
        k   = CntS - $signed(CORDW'(shape_id_q));
        h   = k * RingS + k * GrowS * a_s;
        gx0 = CxS - h;
        gy0 = CyS - h;
        gx1 = CxS + h - CORDW'(1);
        gy1 = CyS + h - CORDW'(1);
        if (shape_id_q == '0) begin
            gx0 = '0;
            gy0 = '0;
            gx1 = WMaxS;
            gy1 = HMaxS;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            shape_id_q   <= '0;
            cidx_q       <= '0;
            draw_start_q <= '0;
            sx0_q        <= '0;
            sy0_q        <= '0;
            sx1_q        <= '0;
            sy1_q        <= '0;
        end else begin
            state_q      <= state_d;
            draw_start_q <= '0;
            case (state_q)
                StIdle: if (start) shape_id_q <= '0;
                StInit: begin
                    sx0_q        <= gx0 * ScaleS;
                    sy0_q        <= gy0 * ScaleS;
                    sx1_q        <= gx1 * ScaleS;
                    sy1_q        <= gy1 * ScaleS;
                    cidx_q       <= colr_offs_q + CIDXW'(shape_id_q);
                    draw_start_q <= outline_q ? 2'b10 : 2'b01;
                end
                StDraw: if (sel_done && !last_shape) shape_id_q <= shape_id_q + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (start) state_d = StInit;
            end
            StInit: state_d = StDraw;
            StDraw: if (sel_done) state_d = last_shape ? StDone : StInit;
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Drawer 0 fills the rectangle; drawer 1 jumps from left to right edge on interior rows.
    for (genvar d = 0; d < 2; d++) begin : g_drawer
        localparam bit Outline = (d == 1);

        logic signed [CORDW-1:0] x_q, y_q, x0_q, y0_q, x1_q, y1_q;
        logic                    act_q, done_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                act_q  <= 1'b0;
                done_q <= 1'b0;
                x_q    <= '0;
                y_q    <= '0;
                x0_q   <= '0;
                y0_q   <= '0;
                x1_q   <= '0;
                y1_q   <= '0;
            end else begin
                done_q <= 1'b0;
                if (draw_start_q[d]) begin
                    x0_q <= sx0_q;
                    y0_q <= sy0_q;
                    x1_q <= sx1_q;
                    y1_q <= sy1_q;
                    x_q  <= sx0_q;
                    y_q  <= sy0_q;
                    if (sx1_q < sx0_q || sy1_q < sy0_q) done_q <= 1'b1;
                    else act_q <= 1'b1;
                end else if (act_q && oe) begin
                    if (x_q == x1_q) begin
                        if (y_q == y1_q) begin
                            act_q  <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            x_q <= x0_q;
                            y_q <= y_q + CORDW'(1);
                        end
                    end else if (Outline && x_q == x0_q && y_q != y0_q && y_q != y1_q) begin
                        x_q <= x1_q;
                    end else begin
                        x_q <= x_q + CORDW'(1);
                    end
                end
            end
        end

        assign drw_x[d]    = x_q;
        assign drw_y[d]    = y_q;
        assign drw_act[d]  = act_q;
        assign drw_done[d] = done_q;
    end

    assign x       = outline_q ? drw_x[1] : drw_x[0];
    assign y       = outline_q ? drw_y[1] : drw_y[0];
    assign drawing = (outline_q ? drw_act[1] : drw_act[0]) && oe;
    assign cidx    = cidx_q;

endmodule

// File: doc/render_tunnel.md
Name: render_tunnel

Overview:
- Parametrised animated nested-rectangle renderer (tunnel/zoom effect) for the animated-shapes framebuffer designs.
- On each accepted start it draws one frame into the framebuffer drawing path: a full-screen background, then SHAPE_CNT-1 concentric squares centred on screen.
- Generalises the fixed 8-shape/320x180 renderer. Shape count, ring geometry, resolution and animation timing are parameters. It adds runtime zoom direction, pause, and fill/outline mode selection.

Parameters:
- CORDW, 16, signed coordinate width (bits)
- CIDXW, 4, colour index width (bits)
- SCALE, 1, integer drawing scale applied to all coordinates
- WIDTH, 320, logical frame width (pixels, before SCALE)
- HEIGHT, 180, logical frame height (pixels, before SCALE)
- SHAPE_CNT, 8, shapes per frame including background (2..16)
- ANIM_CNT, 5, animation steps per cycle (>=2)
- ANIM_SPEED, 3, accepted starts per animation step (>=1)
- RING, 10, half-size increment between adjacent rings (pixels)
- GROW, 1, extra half-size per animation step per ring index (pixels)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- oe  in  1  output enable; low stalls the active drawer
- start  in  1  start a frame (single-cycle pulse)
- dir  in  1  0 = expand (zoom out), 1 = contract (zoom in); sampled on accept
- pause  in  1  1 = animation counters hold on accept
- outline  in  1  0 = filled rectangles, 1 = outlines; sampled on accept
- x  out  CORDW  signed horizontal draw position
- y  out  CORDW  signed vertical draw position
- cidx  out  CIDXW  colour index of the current shape
- drawing  out  1  pixel (x,y,cidx) valid this cycle
- busy  out  1  frame in progress
- done  out  1  frame complete; high for one cycle

Behaviour:
- Reset values: state IDLE; cnt_anim=0; cnt_speed=0; colr_offs=0; shape_id=0; cidx=0; busy=0; done=0; drawing=0.
- x and y hold sub-drawer values and are don't-care while drawing=0.
- Accept rule: start is accepted only in IDLE. Start in any other state is ignored, and the counters do not change.
- Counter update on accept, when pause=0:
  - dir=0: cnt_speed increments. When it reaches ANIM_SPEED-1 it returns to 0 and cnt_anim increments. cnt_anim wraps ANIM_CNT-1 -> 0, and on that wrap colr_offs increments (mod 2^CIDXW).
  - dir=1: cnt_speed is handled the same way. cnt_anim decrements instead, wrapping 0 -> ANIM_CNT-1, and on that wrap colr_offs decrements.
- The frame uses the counter values after the update.
- pause=1: no counters change.
- dir and outline are latched at accept and held for the whole frame.
- State IDLE: on accept, go to INIT with shape_id=0.
- State INIT, one cycle:
  - Register shape coordinates and cidx = colr_offs + shape_id (mod 2^CIDXW).
  - Pulse the selected drawer's start for exactly one cycle, the cycle after INIT.
  - Go to DRAW.
- State DRAW: wait for the selected drawer's done.
  - If shape_id = SHAPE_CNT-1, go to DONE.
  - Otherwise increment shape_id and go to INIT.
- State DONE: done=1 for one cycle, then go to IDLE.
- busy=1 in INIT, DRAW and DONE.
- Geometry, with CX=WIDTH/2, CY=HEIGHT/2 and a=cnt_anim:
  - Shape 0 (background): (0, 0, WIDTH-1, HEIGHT-1).
  - Shape i in 1..SHAPE_CNT-1: k = SHAPE_CNT-i; h = k*RING + k*GROW*a; corners (CX-h, CY-h, CX+h-1, CY+h-1).
  - All arithmetic is signed CORDW. Negative or off-screen coordinates are passed through unclipped.
  - Each coordinate is multiplied by SCALE before reaching the drawer.
- Drawers: one filled-rectangle drawer and one outline-rectangle drawer.
  - Only the latched-mode drawer is started.
  - x, y and drawing are muxed from the latched-mode drawer.
  - oe feeds both drawers.
- Reset mid-frame: reset returns to IDLE within one cycle with busy=0 and drawing=0, aborts the drawers, and clears the counters.

Test Plan:
- Reset values: assert rst 2 cycles -> busy=0, done=0, drawing=0, cidx=0. Next start draws with a=0 and colr_offs=0.
- Filled frame geometry (WIDTH=32, HEIGHT=18, SHAPE_CNT=3, RING=4, GROW=1, outline=0, oe=1): one start -> shapes (0,0,31,17), (8,1,23,16), (12,5,19,12) with cidx 0,1,2 -> exactly 896 drawing cycles, then done high for one cycle, busy low after it.
- Animation and colour wrap (ANIM_SPEED=3, ANIM_CNT=5, dir=0): starts 1-2 use a=0, start 3 uses a=1 (shape 1 becomes (6,-1,25,18)). Start 15 gives a=0 and colr_offs=1, so shape 0 has cidx=1.
- Reverse and pause: dir=1 from reset, 3 starts -> a=4, colr_offs=15 (2^CIDXW-1). With pause=1 held, further starts -> a and colr_offs unchanged.
- Outline mode and start rejection: outline=1, 3-shape config -> drawn pixels equal the perimeters only (96+60+28=184 drawing cycles). A start pulse mid-frame is ignored: no extra frame, counters unchanged.
- Stall and reset: oe=0 for 10 cycles mid-shape -> no drawing, no positions skipped. rst mid-DRAW -> IDLE next cycle, busy=0, no done pulse.
